// File: rtl/arbitro_quatro_pkg.sv
`default_nettype none
// ============================================================================
// Module  : arbitro_quatro_pkg
// Brief   : Shared definitions for the four-way arbiter: FSM state encoding,
//           requester index constants and the default hold limit.
// Revision: 1.0 - initial release
// ============================================================================
package arbitro_quatro_pkg;

  // Arbiter FSM: no owner / exactly one owner
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } state_t;

  // Requester indices (bit positions in req / gnt)
  localparam logic [1:0] A = 2'd0;
  localparam logic [1:0] B = 2'd1;
  localparam logic [1:0] C = 2'd2;
  localparam logic [1:0] D = 2'd3;

  // Default maximum consecutive grant cycles per owner
  localparam int HOLD_MAX_DEFAULT = 8;

  // Encoded index to one-hot grant vector
  function automatic logic [3:0] idx_to_onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/arbitro_prioridade.sv
`default_nettype none
// ============================================================================
// Module  : arbitro_prioridade
// Brief   : Combinational winner search over four requests. Starting at
//           i_start and moving upward with wrap 3->0, returns the first
//           request that is also enabled by i_mask. Fixed priority is
//           obtained with i_start = 0.
// Revision: 1.0 - initial release
// ============================================================================
module arbitro_prioridade
  import arbitro_quatro_pkg::*;
(
  input  logic [3:0] i_req,
  input  logic [1:0] i_start,
  input  logic [3:0] i_mask,
  output logic [1:0] o_idx,
  output logic       o_valid
);

  logic [3:0] w_elig;
  logic [1:0] w_cand;

  // Scan from the farthest candidate back to i_start so the nearest hit wins
  always_comb begin
    w_elig  = i_req & i_mask;
    o_idx   = A;
    o_valid = 1'b0;
    w_cand  = i_start;
    for (int k = 3; k >= 0; k--) begin
      w_cand = i_start + 2'(k);
      if (w_elig[w_cand]) begin
        o_idx   = w_cand;
        o_valid = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/arbitro_quatro.sv
`default_nettype none
// ============================================================================
// Module  : arbitro_quatro
// Brief   : Four-requester locking arbiter with fixed-priority (m=0) or
//           round-robin (m=1) selection, registered one-hot grant and a
//           combinational data mux of the owner's input.
//           Optional macro ARBITRO_TIMEOUT_EN adds an 8-bit hold counter that
//           forces a hand-over after HOLD_MAX cycles when others are waiting.
// Revision: 1.0 - initial release
// ============================================================================
module arbitro_quatro
  import arbitro_quatro_pkg::*;
#(
  parameter int W        = 1,
  parameter int HOLD_MAX = HOLD_MAX_DEFAULT
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         m,
  input  logic [3:0]   req,
  input  logic [W-1:0] din_a,
  input  logic [W-1:0] din_b,
  input  logic [W-1:0] din_c,
  input  logic [W-1:0] din_d,
  output logic [3:0]   gnt,
  output logic [1:0]   gnt_idx,
  output logic         busy,
  output logic [W-1:0] dout
);

  // Reject an out-of-range hold limit at elaboration
  if ((HOLD_MAX < 2) || (HOLD_MAX > 255)) begin : g_hold_max_range
    $error("arbitro_quatro: HOLD_MAX must be in 2..255");
  end

  state_t     r_state;
  logic [3:0] r_gnt;
  logic [1:0] r_gnt_idx;
  logic       r_busy;
  logic [1:0] r_last_owner;

  logic       w_owner_req;
  logic       w_timeout;
  logic       w_arb;
  logic [3:0] w_mask;
  logic [1:0] w_start;
  logic [1:0] w_win_idx;
  logic       w_win_valid;

`ifdef ARBITRO_TIMEOUT_EN
  localparam logic [7:0] c_HOLD_LAST = 8'(HOLD_MAX - 1);

  logic [7:0] r_hold;

  // Owner has used its slot and someone else is waiting
  always_comb begin
    w_timeout = (r_state == OWNED) && (r_hold >= c_HOLD_LAST) && (|(req & ~r_gnt));
  end
`else
  assign w_timeout = 1'b0;
`endif

  // Decide whether to arbitrate this cycle and with which start/mask
  always_comb begin
    w_owner_req = req[r_gnt_idx];
    w_arb       = (r_state == IDLE) ? (|req) : (!w_owner_req || w_timeout);
    // On timeout the current owner is excluded from the search
    w_mask      = w_timeout ? ~r_gnt : 4'hF;
    w_start     = m ? (r_last_owner + 2'd1) : A;
  end

  arbitro_prioridade u_prioridade (
    .i_req   (req),
    .i_start (w_start),
    .i_mask  (w_mask),
    .o_idx   (w_win_idx),
    .o_valid (w_win_valid)
  );

  // FSM with registered grant outputs and (optionally) the hold counter
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_gnt        <= 4'b0000;
      r_gnt_idx    <= A;
      r_busy       <= 1'b0;
      r_last_owner <= D;
`ifdef ARBITRO_TIMEOUT_EN
      r_hold       <= 8'd0;
`endif
    end else if (w_arb) begin
      if (w_win_valid) begin
        r_state      <= OWNED;
        r_gnt        <= idx_to_onehot(w_win_idx);
        r_gnt_idx    <= w_win_idx;
        r_busy       <= 1'b1;
        r_last_owner <= w_win_idx;
      end else begin
        // Owner released and nobody else is waiting; last owner is kept
        r_state      <= IDLE;
        r_gnt        <= 4'b0000;
        r_gnt_idx    <= A;
        r_busy       <= 1'b0;
      end
`ifdef ARBITRO_TIMEOUT_EN
      r_hold <= 8'd0;
`endif
    end else begin
`ifdef ARBITRO_TIMEOUT_EN
      // Count owned cycles, saturating at the hand-over threshold
      if ((r_state == OWNED) && (r_hold < c_HOLD_LAST)) begin
        r_hold <= r_hold + 8'd1;
      end
`endif
    end
  end

  // Data mux follows the registered owner index
  always_comb begin
    dout = '0;
    if (r_busy) begin
      case (r_gnt_idx)
        A:       dout = din_a;
        B:       dout = din_b;
        C:       dout = din_c;
        default: dout = din_d;
      endcase
    end
  end

  assign gnt     = r_gnt;
  assign gnt_idx = r_gnt_idx;
  assign busy    = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_arbitro_quatro.sv
`default_nettype none
// ============================================================================
// Module  : tb_arbitro_quatro
// Brief   : Directed scoreboard bench for arbitro_quatro. The stimulus process
//           drives inputs on the falling edge and queues the grant expected
//           after the next rising edge; a monitor pops and compares.
//           Timeout scenarios run when ARBITRO_TIMEOUT_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
module tb_arbitro_quatro;

  localparam int W = 8;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         m     = 1'b0;
  logic [3:0]   req   = 4'b0000;
  logic [W-1:0] din_a = 8'hA1;
  logic [W-1:0] din_b = 8'hB2;
  logic [W-1:0] din_c = 8'hC3;
  logic [W-1:0] din_d = 8'hD4;
  logic [3:0]   gnt;
  logic [1:0]   gnt_idx;
  logic         busy;
  logic [W-1:0] dout;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string        name;
    logic [3:0]   gnt;
    logic [1:0]   idx;
    logic         busy;
    logic [W-1:0] dout;
  } exp_t;

  exp_t sb_q[$];

  arbitro_quatro #(.W(W), .HOLD_MAX(4)) dut (
    .clock   (clock),
    .reset   (reset),
    .m       (m),
    .req     (req),
    .din_a   (din_a),
    .din_b   (din_b),
    .din_c   (din_c),
    .din_d   (din_d),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .busy    (busy),
    .dout    (dout)
  );

  always #5 clock = ~clock;

  // Build the full expected output from a one-hot (or zero) grant
  function automatic exp_t mk(input string n, input logic [3:0] g);
    exp_t e;
    e.name = n;
    e.gnt  = g;
    e.busy = |g;
    case (g)
      4'b0001: begin e.idx = 2'd0; e.dout = din_a; end
      4'b0010: begin e.idx = 2'd1; e.dout = din_b; end
      4'b0100: begin e.idx = 2'd2; e.dout = din_c; end
      4'b1000: begin e.idx = 2'd3; e.dout = din_d; end
      default: begin e.idx = 2'd0; e.dout = '0;    end
    endcase
    return e;
  endfunction

  task automatic compare(input exp_t e);
    n_checks++;
    if (gnt !== e.gnt || gnt_idx !== e.idx || busy !== e.busy || dout !== e.dout) begin
      n_errors++;
      $display("FAIL %s: got gnt=%b idx=%0d busy=%b dout=%h, want gnt=%b idx=%0d busy=%b dout=%h",
               e.name, gnt, gnt_idx, busy, dout, e.gnt, e.idx, e.busy, e.dout);
    end
  endtask

  // Apply inputs now and queue the outcome of the next rising edge
  task automatic drive(input logic im, input logic [3:0] ir, input logic [3:0] eg, input string n);
    m   = im;
    req = ir;
    sb_q.push_back(mk(n, eg));
  endtask

  task automatic cyc(input logic im, input logic [3:0] ir, input logic [3:0] eg, input string n);
    @(negedge clock);
    drive(im, ir, eg, n);
  endtask

  // Synchronous-looking reset pulse placed on a falling edge
  task automatic reset_pulse(input string n);
    @(negedge clock);
    reset = 1'b1;
    req   = 4'b0000;
    #1;
    compare(mk(n, 4'b0000));
    @(negedge clock);
    reset = 1'b0;
  endtask

  // Monitor: one expectation per rising edge, sampled just after it
  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (sb_q.size() > 0 && !reset) compare(sb_q.pop_front());
    end
  end

  // Stimulus
  initial begin
    repeat (2) @(posedge clock);
    #1;
    compare(mk("reset_state", 4'b0000));
    @(negedge clock);
    reset = 1'b0;

    // Fixed priority, lock and direct hand-over
    cyc(0, 4'b1110, 4'b0010, "fp_b");
    cyc(0, 4'b1110, 4'b0010, "lock_b");
    cyc(0, 4'b0010, 4'b0010, "lock_b_alone");
    cyc(0, 4'b1100, 4'b0100, "handoff_c");
    cyc(0, 4'b0000, 4'b0000, "release_idle");
    cyc(0, 4'b1111, 4'b0001, "fp_all_a");
    cyc(0, 4'b0000, 4'b0000, "idle2");

    // last_owner tracked in fixed mode, then round robin continues from it
    cyc(0, 4'b0100, 4'b0100, "fp_c");
    cyc(1, 4'b0000, 4'b0000, "drop_c");
    cyc(1, 4'b1111, 4'b1000, "rr_after_fp_d");
    cyc(1, 4'b0111, 4'b0001, "rr_wrap_a");
    cyc(1, 4'b1110, 4'b0010, "rr_b");
    cyc(1, 4'b0000, 4'b0000, "idle3");

    // Mode change while owned leaves the grant alone
    cyc(1, 4'b1001, 4'b1000, "rr_skip_c_d");
    cyc(0, 4'b1001, 4'b1000, "m_change_hold");
    cyc(0, 4'b0001, 4'b0001, "fp_after_drop");
    cyc(0, 4'b0000, 4'b0000, "idle4");

    // Asynchronous reset between edges while c owns
    cyc(0, 4'b0100, 4'b0100, "own_c");
    @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    compare(mk("async_reset", 4'b0000));
    @(negedge clock);
    reset = 1'b0;
    drive(1, 4'b1001, 4'b0001, "post_reset_rr_a");
    cyc(1, 4'b0000, 4'b0000, "idle5");

    // Round robin with each owner dropping for one cycle
    reset_pulse("reset_before_rr");
    cyc(1, 4'b1111, 4'b0001, "rr_seq_a");
    cyc(1, 4'b1110, 4'b0010, "rr_seq_b");
    cyc(1, 4'b1101, 4'b0100, "rr_seq_c");
    cyc(1, 4'b1011, 4'b1000, "rr_seq_d");
    cyc(1, 4'b0111, 4'b0001, "rr_seq_a2");
    cyc(1, 4'b0000, 4'b0000, "idle6");

    reset_pulse("reset_before_hold");
`ifdef ARBITRO_TIMEOUT_EN
    // HOLD_MAX=4: a, b alternate every four cycles
    for (int i = 0; i < 4; i++) cyc(0, 4'b0011, 4'b0001, "to_a_slot");
    for (int i = 0; i < 4; i++) cyc(0, 4'b0011, 4'b0010, "to_b_slot");
    cyc(0, 4'b0011, 4'b0001, "to_a_again");
    // Sole requester keeps the grant past the limit
    for (int i = 0; i < 8; i++) cyc(0, 4'b0001, 4'b0001, "to_sole_a");
    // Saturated counter: a newcomer takes over on the next edge
    cyc(0, 4'b0011, 4'b0010, "to_sat_b");
`else
    // Without timeout the owner keeps the grant while requesting
    for (int i = 0; i < 12; i++) cyc(0, 4'b0011, 4'b0001, "no_to_hold_a");
    cyc(0, 4'b0010, 4'b0010, "no_to_b");
`endif
    cyc(0, 4'b0000, 4'b0000, "idle_end");

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 20; i++) begin
      if (sb_q.size() == 0) break;
      @(posedge clock);
      #2;
    end
    if (sb_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d expectations left, want 0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
